// File: rtl/xadc_drp_pkg.sv
// Shared constants and state encodings for the XADC DRP responder.
package xadc_drp_pkg;

  localparam logic [6:0] ADDR_VAUX0 = 7'h10;
  localparam logic [6:0] ADDR_VAUX1 = 7'h11;
  localparam logic [6:0] ADDR_VAUX2 = 7'h12;
  localparam logic [6:0] ADDR_VAUX3 = 7'h13;
  localparam logic [6:0] ADDR_CFG0  = 7'h40;
  localparam logic [6:0] ADDR_CFG1  = 7'h41;
  localparam logic [6:0] ADDR_CFG2  = 7'h42;

  localparam logic [15:0] CFG1_RESET = 16'h0001;
  localparam int unsigned SEQ_EN_BIT = 0;

  typedef enum logic {
    DRP_IDLE,
    DRP_WAIT
  } drp_state_e;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_CONV,
    SEQ_EOS
  } seq_state_e;

endpackage

// File: rtl/xadc_conv_sequencer.sv
// Round-robin auxiliary-channel conversion sequencer with BUSY/EOS/CHANNEL.
// Define XADC_DRP_AVERAGING_EN to publish the mean of every four conversions per channel.
module xadc_conv_sequencer
  import xadc_drp_pkg::*;
#(
  parameter int unsigned CONV_CYCLES = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seq_en_i,
  input  logic [3:0][11:0] sample_i,
  output logic             busy_o,
  output logic             eos_o,
  output logic [4:0]       channel_o,
  output logic             upd_o,
  output logic [1:0]       upd_ch_o,
  output logic [11:0]      upd_code_o
);

  localparam logic [7:0] CNT_LOAD = 8'(CONV_CYCLES - 1);

  seq_state_e  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  ch_q, ch_d;
  logic        conv_done;
  logic [11:0] sample_sel;

  assign conv_done  = (state_q == SEQ_CONV) && (cnt_q == 8'd0);
  assign sample_sel = sample_i[ch_q];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    case (state_q)
      SEQ_IDLE: begin
        if (seq_en_i) begin
          state_d = SEQ_CONV;
          cnt_d   = CNT_LOAD;
          ch_d    = 2'd0;
        end
      end
      SEQ_CONV: begin
        // A disable seen mid-conversion only takes effect once this conversion lands.
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (!seq_en_i) begin
          state_d = SEQ_IDLE;
          ch_d    = 2'd0;
        end else if (ch_q == 2'd3) begin
          state_d = SEQ_EOS;
          ch_d    = 2'd0;
        end else begin
          ch_d  = ch_q + 2'd1;
          cnt_d = CNT_LOAD;
        end
      end
      SEQ_EOS: begin
        if (seq_en_i) begin
          state_d = SEQ_CONV;
          cnt_d   = CNT_LOAD;
          ch_d    = 2'd0;
        end else begin
          state_d = SEQ_IDLE;
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= SEQ_IDLE;
      cnt_q   <= 8'd0;
      ch_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
    end
  end

  assign busy_o    = (state_q == SEQ_CONV);
  assign eos_o     = (state_q == SEQ_EOS);
  assign channel_o = {3'b100, ch_q};
  assign upd_ch_o  = ch_q;

`ifdef XADC_DRP_AVERAGING_EN
  logic [3:0][13:0] acc_q;
  logic [3:0][1:0]  nacc_q;
  logic [13:0]      acc_sum;
  logic             last_of_four;

  assign acc_sum      = acc_q[ch_q] + {2'b00, sample_sel};
  assign last_of_four = (nacc_q[ch_q] == 2'd3);

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q  <= '0;
      nacc_q <= '0;
    end else if (conv_done) begin
      if (last_of_four) begin
        acc_q[ch_q]  <= 14'd0;
        nacc_q[ch_q] <= 2'd0;
      end else begin
        acc_q[ch_q]  <= acc_sum;
        nacc_q[ch_q] <= nacc_q[ch_q] + 2'd1;
      end
    end
  end

  assign upd_o      = conv_done && last_of_four;
  assign upd_code_o = 12'(acc_sum >> 2);
`else
  assign upd_o      = conv_done;
  assign upd_code_o = sample_sel;
`endif

endmodule

// File: rtl/xadc_drp_responder.sv
// XADC DRP responder: status/config register file plus DRP handshake, around the conversion sequencer.
// Build option XADC_DRP_AVERAGING_EN enables four-sample averaging in the sequencer.
module xadc_drp_responder
  import xadc_drp_pkg::*;
#(
  parameter int unsigned CONV_CYCLES = 26,
  parameter int unsigned DRP_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  DADDR,
  input  logic        DEN,
  input  logic [15:0] DI,
  input  logic        DWE,
  output logic [15:0] DO,
  output logic        DRDY,
  output logic        BUSY,
  output logic        EOS,
  output logic [4:0]  CHANNEL,
  input  logic [11:0] sample_aux0,
  input  logic [11:0] sample_aux1,
  input  logic [11:0] sample_aux2,
  input  logic [11:0] sample_aux3,
  output logic        drp_err
);

  localparam logic [3:0] LAT_LOAD = 4'(DRP_LATENCY - 1);

  drp_state_e       drp_state_q, drp_state_d;
  logic [3:0]       lat_q, lat_d;
  logic [6:0]       addr_q;
  logic             we_q;
  logic [15:0]      di_q;
  logic             accept;
  logic             commit;
  logic [6:0]       txn_addr;
  logic             txn_we;
  logic [15:0]      txn_di;
  logic [15:0]      rd_data;
  logic [15:0]      do_q;
  logic [15:0]      cfg0_q, cfg1_q, cfg2_q;
  logic             err_q;
  logic [3:0][11:0] stat_q;
  logic             upd;
  logic [1:0]       upd_ch;
  logic [11:0]      upd_code;

  // commit marks the edge that raises DRDY: read data and write effects land there.
  always_comb begin
    drp_state_d = drp_state_q;
    lat_d       = lat_q;
    accept      = 1'b0;
    case (drp_state_q)
      DRP_IDLE: begin
        if (DEN) begin
          accept      = 1'b1;
          drp_state_d = DRP_WAIT;
          lat_d       = LAT_LOAD;
        end
      end
      DRP_WAIT: begin
        if (lat_q == 4'd0) drp_state_d = DRP_IDLE;
        else               lat_d       = lat_q - 4'd1;
      end
      default: drp_state_d = DRP_IDLE;
    endcase
    commit = (drp_state_d == DRP_WAIT) && (lat_d == 4'd0);
  end

  // With a latency of one the request commits on its own accept edge, before it is latched.
  assign txn_addr = accept ? DADDR : addr_q;
  assign txn_we   = accept ? DWE   : we_q;
  assign txn_di   = accept ? DI    : di_q;

  always_comb begin
    rd_data = 16'h0000;
    case (txn_addr)
      ADDR_VAUX0: rd_data = {stat_q[0], 4'b0000};
      ADDR_VAUX1: rd_data = {stat_q[1], 4'b0000};
      ADDR_VAUX2: rd_data = {stat_q[2], 4'b0000};
      ADDR_VAUX3: rd_data = {stat_q[3], 4'b0000};
      ADDR_CFG0:  rd_data = cfg0_q;
      ADDR_CFG1:  rd_data = cfg1_q;
      ADDR_CFG2:  rd_data = cfg2_q;
      default:    rd_data = 16'h0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      drp_state_q <= DRP_IDLE;
      lat_q       <= 4'd0;
      addr_q      <= 7'd0;
      we_q        <= 1'b0;
      di_q        <= 16'h0000;
      do_q        <= 16'h0000;
      err_q       <= 1'b0;
      cfg0_q      <= 16'h0000;
      cfg1_q      <= CFG1_RESET;
      cfg2_q      <= 16'h0000;
      stat_q      <= '0;
    end else begin
      drp_state_q <= drp_state_d;
      lat_q       <= lat_d;
      if (accept) begin
        addr_q <= DADDR;
        we_q   <= DWE;
        di_q   <= DI;
      end
      if (DEN && (drp_state_q == DRP_WAIT)) err_q <= 1'b1;
      if (commit) begin
        if (!txn_we) begin
          do_q <= rd_data;
        end else begin
          case (txn_addr)
            ADDR_CFG0: cfg0_q <= txn_di;
            ADDR_CFG1: cfg1_q <= txn_di;
            ADDR_CFG2: cfg2_q <= txn_di;
            default: ;
          endcase
        end
      end
      if (upd) stat_q[upd_ch] <= upd_code;
    end
  end

  assign DO      = do_q;
  assign DRDY    = (drp_state_q == DRP_WAIT) && (lat_q == 4'd0);
  assign drp_err = err_q;

  xadc_conv_sequencer #(
    .CONV_CYCLES(CONV_CYCLES)
  ) u_seq (
    .clk       (clk),
    .rst       (rst),
    .seq_en_i  (cfg1_q[SEQ_EN_BIT]),
    .sample_i  ({sample_aux3, sample_aux2, sample_aux1, sample_aux0}),
    .busy_o    (BUSY),
    .eos_o     (EOS),
    .channel_o (CHANNEL),
    .upd_o     (upd),
    .upd_ch_o  (upd_ch),
    .upd_code_o(upd_code)
  );

endmodule
